mips_alu_sequencer: RTL and testbench
=====================================

# mips_alu_sequencer

Multi-cycle issue/retire sequencer that drives the combinational 32-bit MIPS ALU. It accepts one instruction word at a time over a valid/ready handshake and decodes it. It reads operands from an internal 32x32 register file, presents the ALU input fields, samples `ALU_result`/`branch_sig`, writes back, and advances the PC. It is the initiator side of the ALU interface and sits between instruction fetch and the ALU.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `instr_valid  in  1`: instruction word on `instr` is valid.
- `instr  in  32`: MIPS instruction word.
- `instr_ready  out  1`: sequencer can accept; high only in IDLE.
- `opcode`, `funct`  out  6 each: to ALU, registered.
- `rs`, `rt`, `shamt`  out  5 each: to ALU, registered.
- `imm  out  16`: to ALU, registered.
- `rs_value`, `rt_value`  out  32 each: register-file operands to ALU, registered.
- `alu_result  in  32`: ALU `ALU_result`.
- `branch_sig  in  1`: ALU branch flag.
- `retire  out  1`: one-cycle pulse per completed instruction.
- `wb_en  out  1`, `wb_addr  out  5`, `wb_data  out  32`: write-back performed this retire.
- `illegal  out  1`: retired instruction was unsupported; valid with `retire`.
- `ovf  out  1`: signed overflow trap; valid with `retire`. Constant 0 when the trap is compiled out.
- `pc  out  32`: current PC.

## Operation
- States: IDLE, PRIME, EX, WB.
- IDLE -> PRIME on `instr_valid && instr_ready`. `instr` is latched and the register file is read at this edge.
- PRIME -> EX -> WB -> IDLE unconditionally.
- In PRIME, all ALU fields carry their true values except `imm = ~instr[15:0]`. In EX, `imm = instr[15:0]`. The ALU sensitivity excludes `opcode`, so the guaranteed `imm` toggle forces re-evaluation.
- The result is sampled on the EX->WB edge.
- In IDLE, the ALU fields hold their last values.
- Destination is `rd = instr[15:11]` for opcode 0. It is `rt` for ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x12, ORI 0x13 and LUI 0x15 (the ALU's encodings).
- Supported R-type funct values: 0x00, 0x02, 0x03, 0x20–0x25, 0x27, 0x2A, 0x2B.
- BEQ 0x04 and BNE 0x05 have no write-back.
  - If `branch_sig` is 1: `pc <= pc + 4 + (sext(imm) << 2)`.
  - Otherwise: `pc <= pc + 4`.
  - `branch_sig` is ignored for all other opcodes.
- Every other opcode or funct, including loads and stores, retires with `illegal = 1`, `wb_en = 0` and `pc + 4`.
- Register `$0` always reads 0. Writes to `$0` are dropped (`wb_en = 0`).
- All PC arithmetic is modulo 2^32.

## Timing
- Accept at edge T. PRIME runs T..T+1, EX runs T+1..T+2.
- At edge T+2: register-file write, `pc` update, and `retire`/`wb_*`/`illegal`/`ovf` registered high. These are held for exactly one cycle (WB).
- `instr_ready` rises after edge T+3. The earliest next accept is edge T+4, giving 1 instruction per 4 cycles.
- Back-to-back dependency: a write at T+2 is visible to an instruction accepted at T+4.
- `instr_valid` outside IDLE is ignored. The producer must hold `instr` until accepted.
- Reset asserted at any time, including mid-instruction: immediately go to IDLE and abort with no write-back.
  - `pc = RESET_PC`, all 32 registers = 0.
  - `instr_ready = 1`.
  - `retire`, `wb_en`, `illegal`, `ovf` = 0.
  - All ALU-facing outputs = 0.

## Configuration
- `MIPS_SEQ_OVF_TRAP_EN` defined:
  - ADD 0x20, SUB 0x22 and ADDI 0x08 check signed overflow from the operand signs and `alu_result[31]`.
  - On overflow: `ovf = 1`, `wb_en = 0`, register unchanged, `pc + 4`.
- Undefined: `ovf` is tied to 0 and the wrapped result is written.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams.
  - state enum typedef.
  - `dest_sel` helper function.
- Sub-module `mips_regfile`: 2 asynchronous read ports, 1 synchronous write port, `$0` hardwired, asynchronous active-low clear.
- FSM, decode, PC and trap logic live in the top.

## Test plan
- Reset: `rst_n = 0` -> `pc = 0`, `instr_ready = 1`, `retire = 0`. Release, then `ADDI $1,$0,1500` -> `retire` at T+2, `wb_addr = 1`, `wb_data = 1500`, `instr_ready` again after T+3.
- `ADDI $2,$0,12`, `ADDI $3,$0,-10`, then `ADD $4,$2,$3` issued back-to-back -> `wb_data = 2`. Then `SLL $5,$3,2` -> `0xFFFF_FFD8`.
- BEQ with equal values and `imm = 3` at `pc = 0x10` -> `pc = 0x20`. BEQ with unequal values -> `pc = 0x14`, `wb_en = 0`.
- Two identical `ADDI $0,$0,0`-field instructions that differ only in opcode (ADDI vs ORI) -> each retires with its own correct result, proving the PRIME toggle. The write to `$0` gives `wb_en = 0`.
- Opcode 0x23 (LW) or funct 0x3F -> `illegal = 1`, no write, `pc + 4`.
- `rst_n` pulsed low in EX -> no retire, `$` registers cleared, `pc = RESET_PC`. With `MIPS_SEQ_OVF_TRAP_EN`, `ADD` of `0x7FFF_FFFF + 1` -> `ovf = 1`, `wb_en = 0`.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - Shared opcodes, functs, state type and destination decode for the ALU sequencer
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h12;
    localparam logic [5:0] OP_ORI   = 6'h13;
    localparam logic [5:0] OP_LUI   = 6'h15;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_EX    = 2'd2,
        ST_WB    = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       writes;
        logic       branch;
        logic       illegal;
        logic [4:0] addr;
    } dest_t;

    // Anything not explicitly recognised retires as illegal with no write-back.
    function automatic dest_t dest_sel(input logic [31:0] instr);
        dest_t d;
        d.writes  = 1'b0;
        d.branch  = 1'b0;
        d.illegal = 1'b1;
        d.addr    = instr[20:16];
        case (instr[31:26])
            OP_RTYPE: begin
                d.addr = instr[15:11];
                case (instr[5:0])
                    FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
                        d.writes  = 1'b1;
                        d.illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
                d.writes  = 1'b1;
                d.illegal = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                d.branch  = 1'b1;
                d.illegal = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_alu_sequencer_if.sv
// rtl/mips_alu_sequencer_if.sv - Fetch handshake, ALU field and retire bundle of the sequencer
interface mips_alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic        branch_sig;
    logic        retire;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic        ovf;
    logic [31:0] pc;

    modport master (
        input  instr_valid, instr, alu_result, branch_sig,
        output instr_ready, opcode, funct, rs, rt, shamt, imm, rs_value, rt_value,
               retire, wb_en, wb_addr, wb_data, illegal, ovf, pc
    );

    modport slave (
        output instr_valid, instr, alu_result, branch_sig,
        input  instr_ready, opcode, funct, rs, rt, shamt, imm, rs_value, rt_value,
               retire, wb_en, wb_addr, wb_data, illegal, ovf, pc
    );
endinterface

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async reads, one sync write, $0 hardwired to zero
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr0,
    output logic [31:0] rd_data0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data1,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'h0 : regs_q[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs_q[rd_addr1];

endmodule

// File: rtl/mips_alu_sequencer.sv
// rtl/mips_alu_sequencer.sv - Four-state issue/retire sequencer around a combinational MIPS ALU
// Optional signed-overflow trap on ADD/SUB/ADDI: define MIPS_SEQ_OVF_TRAP_EN.
module mips_alu_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_alu_sequencer_if.master bus
);

    seq_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [5:0]  opcode_q, opcode_d, funct_q, funct_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d, shamt_q, shamt_d;
    logic [15:0] imm_q, imm_d;
    logic [31:0] rs_value_q, rs_value_d, rt_value_q, rt_value_d;
    logic        retire_q, retire_d, wb_en_q, wb_en_d, illegal_q, illegal_d, ovf_q, ovf_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d, pc_q, pc_d;
    logic [31:0] rd_data0, rd_data1, br_off;
    logic        ovf_det;
    dest_t       dest;

    mips_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (bus.instr[25:21]),
        .rd_data0 (rd_data0),
        .rd_addr1 (bus.instr[20:16]),
        .rd_data1 (rd_data1),
        .we       (state_q == ST_EX && wb_en_d),
        .waddr    (wb_addr_d),
        .wdata    (wb_data_d)
    );

    assign dest   = dest_sel(instr_q);
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

`ifdef MIPS_SEQ_OVF_TRAP_EN
    // Overflow when both addends share a sign that the result does not.
    always_comb begin
        ovf_det = 1'b0;
        if (instr_q[31:26] == OP_RTYPE && instr_q[5:0] == FN_ADD) begin
            ovf_det = (rs_value_q[31] == rt_value_q[31]) && (bus.alu_result[31] != rs_value_q[31]);
        end else if (instr_q[31:26] == OP_RTYPE && instr_q[5:0] == FN_SUB) begin
            ovf_det = (rs_value_q[31] != rt_value_q[31]) && (bus.alu_result[31] != rs_value_q[31]);
        end else if (instr_q[31:26] == OP_ADDI) begin
            ovf_det = (rs_value_q[31] == instr_q[15]) && (bus.alu_result[31] != rs_value_q[31]);
        end
    end
`else
    assign ovf_det = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        shamt_d    = shamt_q;
        imm_d      = imm_q;
        rs_value_d = rs_value_q;
        rt_value_d = rt_value_q;
        retire_d   = 1'b0;
        wb_en_d    = 1'b0;
        illegal_d  = 1'b0;
        ovf_d      = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        pc_d       = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    state_d    = ST_PRIME;
                    instr_d    = bus.instr;
                    opcode_d   = bus.instr[31:26];
                    rs_d       = bus.instr[25:21];
                    rt_d       = bus.instr[20:16];
                    shamt_d    = bus.instr[10:6];
                    funct_d    = bus.instr[5:0];
                    // Inverted first so the EX value is always a change the ALU sees.
                    imm_d      = ~bus.instr[15:0];
                    rs_value_d = rd_data0;
                    rt_value_d = rd_data1;
                end
            end
            ST_PRIME: begin
                state_d = ST_EX;
                imm_d   = instr_q[15:0];
            end
            ST_EX: begin
                state_d   = ST_WB;
                retire_d  = 1'b1;
                illegal_d = dest.illegal;
                ovf_d     = ovf_det;
                wb_en_d   = dest.writes && (dest.addr != 5'd0) && !ovf_det;
                wb_addr_d = dest.addr;
                wb_data_d = bus.alu_result;
                pc_d      = (dest.branch && bus.branch_sig) ? pc_q + 32'd4 + br_off : pc_q + 32'd4;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= 32'h0;
            opcode_q   <= 6'h0;
            funct_q    <= 6'h0;
            rs_q       <= 5'h0;
            rt_q       <= 5'h0;
            shamt_q    <= 5'h0;
            imm_q      <= 16'h0;
            rs_value_q <= 32'h0;
            rt_value_q <= 32'h0;
            retire_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            ovf_q      <= 1'b0;
            wb_addr_q  <= 5'h0;
            wb_data_q  <= 32'h0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            opcode_q   <= opcode_d;
            funct_q    <= funct_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            shamt_q    <= shamt_d;
            imm_q      <= imm_d;
            rs_value_q <= rs_value_d;
            rt_value_q <= rt_value_d;
            retire_q   <= retire_d;
            wb_en_q    <= wb_en_d;
            illegal_q  <= illegal_d;
            ovf_q      <= ovf_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.opcode      = opcode_q;
    assign bus.funct       = funct_q;
    assign bus.rs          = rs_q;
    assign bus.rt          = rt_q;
    assign bus.shamt       = shamt_q;
    assign bus.imm         = imm_q;
    assign bus.rs_value    = rs_value_q;
    assign bus.rt_value    = rt_value_q;
    assign bus.retire      = retire_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal     = illegal_q;
    assign bus.ovf         = ovf_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// tb/tb_mips_alu_sequencer.sv - Directed and random checks of the sequencer against an architectural model
module tb_mips_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] regs_m [32];
    logic [31:0] pc_m;

    logic        cap_wb_en, cap_ovf, cap_illegal;
    logic [4:0]  cap_wb_addr;
    logic [31:0] cap_wb_data, cap_pc;

    mips_alu_sequencer_if bus ();

    mips_alu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // MIPS instruction semantics: {branch_taken, result}
    function automatic logic [32:0] alu_model(input logic [5:0] op, input logic [5:0] fn,
                                              input logic [4:0] sh, input logic [15:0] im,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, se, ze;
        logic        br;
        r  = 32'h0;
        br = 1'b0;
        se = {{16{im[15]}}, im};
        ze = {16'h0, im};
        case (op)
            6'h00: case (fn)
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = $unsigned($signed(b) >>> sh);
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h27: r = ~(a | b);
                6'h2A: r = {31'h0, $signed(a) < $signed(b)};
                6'h2B: r = {31'h0, a < b};
                default: r = 32'h0;
            endcase
            6'h08, 6'h09: r = a + se;
            6'h0A: r = {31'h0, $signed(a) < $signed(se)};
            6'h0B: r = {31'h0, a < se};
            6'h12: r = a & ze;
            6'h13: r = a | ze;
            6'h15: r = {im, 16'h0};
            6'h04: br = (a == b);
            6'h05: br = (a != b);
            default: r = 32'h0;
        endcase
        return {br, r};
    endfunction

    logic [32:0] alu_out;
    always_comb begin
        alu_out        = alu_model(bus.opcode, bus.funct, bus.shamt, bus.imm, bus.rs_value, bus.rt_value);
        bus.alu_result = alu_out[31:0];
        bus.branch_sig = alu_out[32];
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
        pc_m = 32'h0;
    endtask

    task automatic issue(input logic [31:0] ins, input string tag);
        logic [31:0] a, b, res, exp_pc;
        logic [32:0] t;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic        legal, brop, ovf_e, wen;
        int          waited;
`ifdef MIPS_SEQ_OVF_TRAP_EN
        longint      sa, sb, s;
`endif
        waited = 0;
        while (bus.instr_ready !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_ready"}, {31'h0, bus.instr_ready}, 32'd1);

        op  = ins[31:26];
        fn  = ins[5:0];
        a   = regs_m[ins[25:21]];
        b   = regs_m[ins[20:16]];
        t   = alu_model(op, fn, ins[10:6], ins[15:0], a, b);
        res = t[31:0];
        brop = (op == 6'h04) || (op == 6'h05);
        if (op == 6'h00) begin
            legal = fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                               6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};
            dst   = ins[15:11];
        end else begin
            legal = op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h12, 6'h13, 6'h15};
            dst   = ins[20:16];
        end
        ovf_e = 1'b0;
`ifdef MIPS_SEQ_OVF_TRAP_EN
        if ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08) begin
            sa = longint'($signed(a));
            sb = (op == 6'h08) ? longint'($signed(ins[15:0])) : longint'($signed(b));
            s  = (op == 6'h00 && fn == 6'h22) ? sa - sb : sa + sb;
            ovf_e = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
`endif
        wen    = legal && !brop && (dst != 5'd0) && !ovf_e;
        exp_pc = (brop && t[32]) ? pc_m + 32'd4 + 32'(signed'(ins[15:0])) * 32'd4 : pc_m + 32'd4;

        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        chk({tag, "_busy"},      {31'h0, bus.instr_ready}, 32'd0);
        chk({tag, "_prime_imm"}, {16'h0, bus.imm}, {16'h0, ~ins[15:0]});
        chk({tag, "_prime_op"},  {26'h0, bus.opcode}, {26'h0, op});
        @(posedge clk); #1;
        chk({tag, "_ex_imm"},    {16'h0, bus.imm}, {16'h0, ins[15:0]});
        chk({tag, "_ex_noret"},  {31'h0, bus.retire}, 32'd0);
        @(posedge clk); #1;
        cap_wb_en   = bus.wb_en;
        cap_wb_addr = bus.wb_addr;
        cap_wb_data = bus.wb_data;
        cap_ovf     = bus.ovf;
        cap_illegal = bus.illegal;
        cap_pc      = bus.pc;
        chk({tag, "_retire"},  {31'h0, bus.retire}, 32'd1);
        chk({tag, "_illegal"}, {31'h0, bus.illegal}, {31'h0, !legal});
        chk({tag, "_ovf"},     {31'h0, bus.ovf}, {31'h0, ovf_e});
        chk({tag, "_wb_en"},   {31'h0, bus.wb_en}, {31'h0, wen});
        if (wen) begin
            chk({tag, "_wb_addr"}, {27'h0, bus.wb_addr}, {27'h0, dst});
            chk({tag, "_wb_data"}, bus.wb_data, res);
        end
        chk({tag, "_pc"}, bus.pc, exp_pc);
        @(posedge clk); #1;
        chk({tag, "_ret_pulse"}, {31'h0, bus.retire}, 32'd0);
        chk({tag, "_ready_back"}, {31'h0, bus.instr_ready}, 32'd1);

        if (wen) regs_m[dst] = res;
        pc_m = exp_pc;
    endtask

    logic [5:0] op_tab [13];
    logic [5:0] fn_tab [14];
    logic [5:0] r_op, r_fn;

    initial begin
        op_tab = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h12, 6'h13, 6'h15, 6'h04, 6'h05, 6'h23};
        fn_tab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h08};

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        model_reset();
        #12;
        chk("rst_pc",      bus.pc, 32'h0);
        chk("rst_ready",   {31'h0, bus.instr_ready}, 32'd1);
        chk("rst_retire",  {31'h0, bus.retire}, 32'd0);
        chk("rst_wb_en",   {31'h0, bus.wb_en}, 32'd0);
        chk("rst_opcode",  {26'h0, bus.opcode}, 32'd0);
        chk("rst_imm",     {16'h0, bus.imm}, 32'd0);
        chk("rst_rsval",   bus.rs_value, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(enc_i(6'h08, 5'd0, 5'd1, 16'd1500), "addi1");
        chk("addi1_addr", {27'h0, cap_wb_addr}, 32'd1);
        chk("addi1_data", cap_wb_data, 32'd1500);
        issue(enc_i(6'h08, 5'd0, 5'd2, 16'd12), "addi2");
        issue(enc_i(6'h08, 5'd0, 5'd3, 16'hFFF6), "addi3");
        issue(enc_r(5'd2, 5'd3, 5'd4, 5'd0, 6'h20), "add4");
        chk("add4_data", cap_wb_data, 32'd2);
        chk("pc_before_beq", cap_pc, 32'h10);
        issue(enc_i(6'h04, 5'd2, 5'd2, 16'd3), "beq_t");
        chk("beq_t_pc", cap_pc, 32'h20);
        issue(enc_i(6'h04, 5'd2, 5'd3, 16'd5), "beq_n");
        chk("beq_n_pc", cap_pc, 32'h24);
        chk("beq_n_wb", {31'h0, cap_wb_en}, 32'd0);
        issue(enc_r(5'd0, 5'd3, 5'd5, 5'd2, 6'h00), "sll5");
        chk("sll5_data", cap_wb_data, 32'hFFFF_FFD8);
        issue(enc_i(6'h08, 5'd3, 5'd6, 16'h0109), "addi6");
        chk("addi6_data", cap_wb_data, 32'h0000_00FF);
        issue(enc_i(6'h13, 5'd3, 5'd6, 16'h0109), "ori6");
        chk("ori6_data", cap_wb_data, 32'hFFFF_FFFF);
        issue(enc_i(6'h08, 5'd0, 5'd0, 16'd5), "addi_r0");
        chk("addi_r0_wb", {31'h0, cap_wb_en}, 32'd0);
        issue(enc_i(6'h23, 5'd1, 5'd7, 16'd4), "lw");
        chk("lw_illegal", {31'h0, cap_illegal}, 32'd1);
        issue(enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h3F), "fn3f");
        chk("fn3f_illegal", {31'h0, cap_illegal}, 32'd1);

        bus.instr       = enc_i(6'h08, 5'd0, 5'd7, 16'd99);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_retire", {31'h0, bus.retire}, 32'd0);
        chk("mid_rst_pc",     bus.pc, 32'h0);
        chk("mid_rst_ready",  {31'h0, bus.instr_ready}, 32'd1);
        chk("mid_rst_imm",    {16'h0, bus.imm}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("post_rst_retire", {31'h0, bus.retire}, 32'd0);
        issue(enc_r(5'd1, 5'd1, 5'd8, 5'd0, 6'h20), "add_cleared");
        chk("cleared_data", cap_wb_data, 32'd0);
        chk("cleared_pc", cap_pc, 32'd4);

        issue(enc_i(6'h15, 5'd0, 5'd9, 16'h7FFF), "lui9");
        issue(enc_i(6'h13, 5'd9, 5'd9, 16'hFFFF), "ori9");
        issue(enc_i(6'h08, 5'd0, 5'd10, 16'd1), "addi10");
        issue(enc_r(5'd9, 5'd10, 5'd11, 5'd0, 6'h20), "add_ovf");
`ifdef MIPS_SEQ_OVF_TRAP_EN
        chk("trap_ovf", {31'h0, cap_ovf}, 32'd1);
        chk("trap_wb",  {31'h0, cap_wb_en}, 32'd0);
`else
        chk("wrap_ovf",  {31'h0, cap_ovf}, 32'd0);
        chk("wrap_data", cap_wb_data, 32'h8000_0000);
`endif

        for (int k = 0; k < 40; k++) begin
            r_op = op_tab[$urandom_range(0, 12)];
            r_fn = fn_tab[$urandom_range(0, 13)];
            if (r_op == 6'h00) begin
                issue(enc_r(5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                            5'($urandom_range(0, 11)), 5'($urandom_range(0, 31)), r_fn), "rand_r");
            end else begin
                issue(enc_i(r_op, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                            16'($urandom)), "rand_i");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
